// File: rtl/store_buffer.sv
// Posted-write store buffer between the MEM-stage store path and data memory.
// Retires stores in order and forwards the youngest matching entry to loads.
module store_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    st_valid,
  input  logic [ADDR_WIDTH-1:0]   st_addr,
  input  logic [DATA_WIDTH-1:0]   st_data,
  input  logic                    drain_en,
  input  logic [ADDR_WIDTH-1:0]   ld_addr,
  input  logic [DATA_WIDTH-1:0]   ld_data_mem,
  output logic [DATA_WIDTH-1:0]   ld_data,
  output logic                    ld_hit,
  output logic                    mem_write_en,
  output logic [ADDR_WIDTH-1:0]   mem_write_addr,
  output logic [DATA_WIDTH-1:0]   mem_write_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [PW-1:0]         head_q;
  logic [PW-1:0]         tail_q;
  logic [PW:0]           count_q;
  logic [PW-1:0]         fwd_idx;
  logic                  push;
  logic                  pop;

  assign empty          = (count_q == '0);
  assign full           = (count_q == FULL_CNT);
  assign count          = count_q;
  assign mem_write_en   = ~empty & drain_en;
  assign mem_write_addr = addr_q[head_q];
  assign mem_write_data = data_q[head_q];

  // A full buffer refuses stores even if the head retires this cycle.
  assign push = st_valid & ~stall & ~full;
  // The head leaves on the same edge at which memory commits it.
  assign pop  = mem_write_en & ~stall;

  // Pointer, occupancy and valid-bit bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry payload storage; left untouched by reset.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= st_addr;
      data_q[tail_q] <= st_data;
    end
  end

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    ld_data = ld_data_mem;
    ld_hit  = 1'b0;
    fwd_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + i[PW-1:0];
      if (valid_q[fwd_idx] && addr_q[fwd_idx] == ld_addr) begin
        ld_data = data_q[fwd_idx];
        ld_hit  = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed stores/drains, scoreboard on the
// memory write port, direct checks on occupancy and forwarding.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        drain_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data_mem;
  logic [31:0] ld_data;
  logic        ld_hit;
  logic        mem_write_en;
  logic [31:0] mem_write_addr;
  logic [31:0] mem_write_data;
  logic        full;
  logic        empty;
  logic [2:0]  count;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t sb[$];
  int  d_tests = 0;
  int  d_fails = 0;
  int  m_tests = 0;
  int  m_fails = 0;
  int  mcount  = 0;
  int  mpush   = 0;
  int  mpop    = 0;

  store_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .st_valid       (st_valid),
    .st_addr        (st_addr),
    .st_data        (st_data),
    .drain_en       (drain_en),
    .ld_addr        (ld_addr),
    .ld_data_mem    (ld_data_mem),
    .ld_data        (ld_data),
    .ld_hit         (ld_hit),
    .mem_write_en   (mem_write_en),
    .mem_write_addr (mem_write_addr),
    .mem_write_data (mem_write_data),
    .full           (full),
    .empty          (empty),
    .count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every committed memory write must match the oldest expected store.
  always @(negedge clk) begin
    if (!reset && mem_write_en && !stall) begin
      m_tests++;
      if (sb.size() == 0) begin
        m_fails++;
        $display("FAIL wr_unexpected: addr 0x%0h data 0x%0h, no write expected",
                 mem_write_addr, mem_write_data);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if (mem_write_addr !== e.a || mem_write_data !== e.d) begin
          m_fails++;
          $display("FAIL wr_order: got 0x%0h/0x%0h expected 0x%0h/0x%0h",
                   mem_write_addr, mem_write_data, e.a, e.d);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    d_tests++;
    if (act !== exp) begin
      d_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sv, input logic [31:0] sa,
                       input logic [31:0] sd, input logic de,
                       input logic stl);
    st_valid = sv;
    st_addr  = sa;
    st_data  = sd;
    drain_en = de;
    stall    = stl;
    mpush = (sv && !stl && mcount != DEPTH) ? 1 : 0;
    mpop  = (de && !stl && mcount != 0) ? 1 : 0;
    if (mpush == 1) sb.push_back('{a: sa, d: sd});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mcount   = mcount + mpush - mpop;
    mpush    = 0;
    mpop     = 0;
    st_valid = 1'b0;
    drain_en = 1'b0;
    stall    = 1'b0;
  endtask

  task automatic step(input logic sv, input logic [31:0] sa,
                      input logic [31:0] sd, input logic de,
                      input logic stl);
    drive(sv, sa, sd, de, stl);
    tick();
  endtask

  initial begin
    reset       = 1'b1;
    stall       = 1'b0;
    st_valid    = 1'b0;
    st_addr     = '0;
    st_data     = '0;
    drain_en    = 1'b0;
    ld_addr     = 32'h0;
    ld_data_mem = 32'h5555;
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_wen", mem_write_en, 0);
    chk("rst_hit", ld_hit, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Fill to capacity with draining disabled.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'h10 + i, 32'h100 + i, 1'b0, 1'b0);
      chk("fill_count", count, i + 1);
    end
    chk("fill_full", full, 1);
    step(1'b1, 32'h14, 32'h104, 1'b0, 1'b0);
    chk("fill_reject", count, 4);
    chk("fill_full2", full, 1);

    // Drain in order from full.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 0, 0, 1'b1, 1'b0);
      chk("drain_count", count, 3 - i);
    end
    chk("drain_empty", empty, 1);

    // Forwarding: youngest duplicate wins, misses fall through.
    step(1'b1, 32'h20, 32'hAAAA, 1'b0, 1'b0);
    step(1'b1, 32'h20, 32'hBBBB, 1'b0, 1'b0);
    ld_addr = 32'h20;
    #1;
    chk("fwd_data", ld_data, 32'hBBBB);
    chk("fwd_hit", ld_hit, 1);
    ld_addr = 32'h24;
    #1;
    chk("miss_data", ld_data, 32'h5555);
    chk("miss_hit", ld_hit, 0);
    drive(1'b1, 32'h30, 32'h3333, 1'b0, 1'b0);
    ld_addr = 32'h30;
    #1;
    chk("push_invisible", ld_hit, 0);
    tick();
    chk("push_visible", ld_data, 32'h3333);
    drive(1'b0, 0, 0, 1'b1, 1'b0);
    ld_addr = 32'h20;
    #1;
    chk("pop_wen", mem_write_en, 1);
    chk("pop_fwd", ld_data, 32'hBBBB);
    tick();
    chk("pre_sim_count", count, 2);

    // Simultaneous push and pop, wrapping both pointers.
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 32'h40 + k, 32'h4000 + k, 1'b1, 1'b0);
      chk("sim_count", count, 2);
    end
    ld_addr = 32'h42;
    #1;
    chk("wrap_fwd", ld_data, 32'h4002);
    chk("wrap_hit", ld_hit, 1);

    // Stall freezes everything while requests are held.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h50, 32'h5000, 1'b1, 1'b1);
      #1;
      chk("stall_wen", mem_write_en, 1);
      tick();
      chk("stall_count", count, 2);
    end
    step(1'b1, 32'h51, 32'h5100, 1'b1, 1'b0);
    chk("resume_count", count, 2);
    step(1'b0, 0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 0, 1'b1, 1'b0);
    chk("resume_empty", empty, 1);

    // Asynchronous reset in the middle of a drain.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h60 + i, 32'h6000 + i, 1'b0, 1'b0);
    end
    chk("pre_rst_count", count, 3);
    drive(1'b0, 0, 0, 1'b1, 1'b0);
    ld_addr = 32'h60;
    #1;
    chk("pre_rst_wen", mem_write_en, 1);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_empty", empty, 1);
    chk("arst_count", count, 0);
    chk("arst_wen", mem_write_en, 0);
    chk("arst_hit", ld_hit, 0);
    chk("arst_data", ld_data, 32'h5555);
    sb.delete();
    mcount = 0;
    mpop   = 0;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    drain_en = 1'b0;

    // Normal operation after reset.
    step(1'b1, 32'h70, 32'h7000, 1'b0, 1'b0);
    chk("post_count", count, 1);
    step(1'b0, 0, 0, 1'b1, 1'b0);
    chk("post_empty", empty, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed",
             d_tests + m_tests, d_fails + m_fails);
    $finish;
  end

endmodule
